// File: rtl/bsk_prd_pkg.sv
// BSK command-receiver board: register addresses,
// reset constants and control bit positions.
package bsk_prd_pkg;
   localparam logic [1:0] ADDR_COM  = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd1;
   localparam logic [1:0] ADDR_CTRL = 2'd2;
   localparam logic [1:0] ADDR_ID   = 2'd3;

   localparam logic [15:0] MASK_RST = 16'h00FF;

   localparam int CTRL_TEST = 0;
   localparam int CTRL_LAMP = 1;
endpackage

// File: rtl/bsk_sync2.sv
// Two-flop synchronizer with asynchronous
// active-low reset and selectable reset value.
module bsk_sync2 #(
   parameter int           W   = 1,
   parameter logic [W-1:0] RST = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   logic [W-1:0] r_s1;
   logic [W-1:0] r_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= RST;
         r_s2 <= RST;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   assign o_q = r_s2;
endmodule

// File: rtl/bsk_prd.sv
// BSK PRD board: command sampling, indicator drive
// and password-protected host register interface.
module bsk_prd
   import bsk_prd_pkg::*;
#(
   parameter logic [6:0] VERSION  = 7'h25,
   parameter logic [7:0] PASSWORD = 8'hA4,
   parameter logic [3:0] CS       = 4'b1011
) (
   input  logic        clk,
   input  logic        iRes,
   inout  wire  [15:0] bD,
   input  logic        iRd,
   input  logic        iWr,
   input  logic        iBl,
   input  logic        iDevice,
   input  logic [1:0]  iA,
   input  logic [3:0]  iCS,
   input  logic [15:0] iCom,
   output logic [15:0] oComInd,
   output logic        oCS,
   output logic        test
);
   logic [15:0] w_com;
   logic        w_wr_s;
   logic        w_sel;
   logic        w_fire;
   logic [15:0] w_rdata;
   logic        w_unused;

   logic        r_wr_d;
   logic [15:0] r_mask;
   logic [1:0]  r_ctrl;
   logic        r_unlock;
   logic [15:0] r_ind;
   logic        r_test;

   assign w_unused = iDevice;

   bsk_sync2 #(.W(16), .RST(16'h0000)) u_com (
      .clk   (clk),
      .rst_n (iRes),
      .i_d   (iCom),
      .o_q   (w_com)
   );

   // Strobe idles high, so reset it high to avoid a phantom edge.
   bsk_sync2 #(.W(1), .RST(1'b1)) u_wr (
      .clk   (clk),
      .rst_n (iRes),
      .i_d   (iWr),
      .o_q   (w_wr_s)
   );

   assign w_sel  = (iCS == CS);
   assign oCS    = ~w_sel;
   assign w_fire = r_wr_d & ~w_wr_s & w_sel & iRd;

   always_comb begin
      w_rdata = 16'h0000;
      case (iA)
         ADDR_COM:  w_rdata = w_com;
         ADDR_MASK: w_rdata = r_mask;
         ADDR_CTRL: w_rdata = {14'h0000, r_ctrl};
         default:   w_rdata = {PASSWORD, 1'b0, VERSION};
      endcase
   end

   assign bD = (w_sel && !iRd) ? w_rdata : 16'hzzzz;

   always_ff @(posedge clk or negedge iRes) begin
      if (!iRes) begin
         r_wr_d   <= 1'b1;
         r_mask   <= MASK_RST;
         r_ctrl   <= 2'b00;
         r_unlock <= 1'b0;
      end else begin
         r_wr_d <= w_wr_s;
         if (w_fire) begin
            case (iA)
               ADDR_ID: r_unlock <= (bD[7:0] == PASSWORD);
               ADDR_MASK: begin
                  if (r_unlock) r_mask <= bD;
                  r_unlock <= 1'b0;
               end
               ADDR_CTRL: begin
                  if (r_unlock) r_ctrl <= bD[1:0];
                  r_unlock <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge iRes) begin
      if (!iRes) begin
         r_ind  <= 16'hFFFF;
         r_test <= 1'b0;
      end else begin
         if (!iBl)
            r_ind <= 16'hFFFF;
         else
            r_ind <= ~((w_com & r_mask) |
                       {16{r_ctrl[CTRL_LAMP]}});
         r_test <= r_ctrl[CTRL_TEST] ? ~r_test : 1'b0;
      end
   end

   assign oComInd = r_ind;
   assign test    = r_test;
endmodule

// File: tb/tb_bsk_prd.sv
// Directed bench for bsk_prd: chip select, reset reads,
// command path, locked writes, blocking, lamp and test output.
module tb_bsk_prd;
   logic        clk;
   logic        iRes;
   logic        iRd;
   logic        iWr;
   logic        iBl;
   logic        iDevice;
   logic [1:0]  iA;
   logic [3:0]  iCS;
   logic [15:0] iCom;
   logic [15:0] oComInd;
   logic        oCS;
   logic        test;
   wire  [15:0] bD;
   logic [15:0] r_drv;
   logic        r_drv_en;

   int pass_cnt = 0;
   int total    = 0;

   assign bD = r_drv_en ? r_drv : 16'hzzzz;
   pullup (bD[0]);  pullup (bD[1]);  pullup (bD[2]);  pullup (bD[3]);
   pullup (bD[4]);  pullup (bD[5]);  pullup (bD[6]);  pullup (bD[7]);
   pullup (bD[8]);  pullup (bD[9]);  pullup (bD[10]); pullup (bD[11]);
   pullup (bD[12]); pullup (bD[13]); pullup (bD[14]); pullup (bD[15]);

   bsk_prd dut (
      .clk     (clk),
      .iRes    (iRes),
      .bD      (bD),
      .iRd     (iRd),
      .iWr     (iWr),
      .iBl     (iBl),
      .iDevice (iDevice),
      .iA      (iA),
      .iCS     (iCS),
      .iCom    (iCom),
      .oComInd (oComInd),
      .oCS     (oCS),
      .test    (test)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_read(input logic [1:0] a, output logic [15:0] d);
      @(negedge clk);
      iA  = a;
      iRd = 1'b0;
      #1 d = bD;
      iRd = 1'b1;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [15:0] v);
      @(negedge clk);
      iA       = a;
      r_drv    = v;
      r_drv_en = 1'b1;
      iRd      = 1'b1;
      iWr      = 1'b0;
      repeat (5) @(negedge clk);
      iWr = 1'b1;
      repeat (4) @(negedge clk);
      r_drv_en = 1'b0;
   endtask

   task automatic test_cs();
      logic [3:0] cs_v [4];
      logic       exp  [4];
      cs_v = '{4'b0000, 4'b1111, 4'b1011, 4'b1111};
      exp  = '{1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         iCS = cs_v[i];
         #1;
         total++;
         if (oCS !== exp[i])
            $display("FAIL cs_%0d: oCS=%b expected %b", i, oCS, exp[i]);
         else pass_cnt++;
      end
      iCS = 4'b0000;
      iA  = 2'd3;
      iRd = 1'b0;
      #1;
      total++;
      if (bD !== 16'hFFFF)
         $display("FAIL bus_release: bD=%h expected pulled-up FFFF", bD);
      else pass_cnt++;
      iRd = 1'b1;
      iCS = 4'b1011;
      #1;
   endtask

   task automatic test_reset();
      logic [15:0] d;
      do_read(2'd3, d);
      total++;
      if (d !== 16'hA425) $display("FAIL rst_id: got %h expected A425", d);
      else pass_cnt++;
      do_read(2'd1, d);
      total++;
      if (d !== 16'h00FF) $display("FAIL rst_mask: got %h expected 00FF", d);
      else pass_cnt++;
      iCom = 16'h1111;
      repeat (3) @(negedge clk);
      do_read(2'd1, d);
      total++;
      if (d !== 16'h00FF) $display("FAIL rst_mask2: got %h expected 00FF", d);
      else pass_cnt++;
      do_read(2'd0, d);
      total++;
      if (d !== 16'h0000) $display("FAIL rst_com: got %h expected 0000", d);
      else pass_cnt++;
      total++;
      if (oComInd !== 16'hFFFF || test !== 1'b0)
         $display("FAIL rst_out: ind=%h test=%b expected FFFF 0", oComInd, test);
      else pass_cnt++;
   endtask

   task automatic test_com();
      logic [15:0] d;
      @(negedge clk);
      iRes = 1'b1;
      iCom = 16'hAA55;
      iBl  = 1'b1;
      repeat (4) @(negedge clk);
      do_read(2'd0, d);
      total++;
      if (d !== 16'hAA55) $display("FAIL com_read: got %h expected AA55", d);
      else pass_cnt++;
      total++;
      if (oComInd !== 16'hFFAA)
         $display("FAIL com_ind: got %h expected FFAA", oComInd);
      else pass_cnt++;
   endtask

   task automatic test_mask_lock();
      logic [15:0] d;
      do_write(2'd1, 16'h1234);
      do_read(2'd1, d);
      total++;
      if (d !== 16'h00FF) $display("FAIL mask_locked: got %h expected 00FF", d);
      else pass_cnt++;
      do_write(2'd3, 16'h00A4);
      do_write(2'd1, 16'hFFFF);
      do_read(2'd1, d);
      total++;
      if (d !== 16'hFFFF) $display("FAIL mask_unlocked: got %h expected FFFF", d);
      else pass_cnt++;
      do_write(2'd1, 16'h0000);
      do_read(2'd1, d);
      total++;
      if (d !== 16'hFFFF) $display("FAIL mask_relock: got %h expected FFFF", d);
      else pass_cnt++;
      total++;
      if (oComInd !== 16'h55AA)
         $display("FAIL mask_ind: got %h expected 55AA", oComInd);
      else pass_cnt++;
   endtask

   task automatic test_rd_wr_conflict();
      logic [15:0] d;
      do_write(2'd3, 16'h00A4);
      @(negedge clk);
      iA  = 2'd1;
      iRd = 1'b0;
      iWr = 1'b0;
      repeat (5) @(negedge clk);
      iWr = 1'b1;
      iRd = 1'b1;
      repeat (4) @(negedge clk);
      do_read(2'd1, d);
      total++;
      if (d !== 16'hFFFF) $display("FAIL rdwr_mask: got %h expected FFFF", d);
      else pass_cnt++;
      do_write(2'd3, 16'h0055);
      do_write(2'd1, 16'h0F0F);
      do_read(2'd1, d);
      total++;
      if (d !== 16'hFFFF) $display("FAIL bad_pw: got %h expected FFFF", d);
      else pass_cnt++;
   endtask

   task automatic test_block();
      logic [15:0] d;
      iBl = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (oComInd !== 16'hFFFF)
         $display("FAIL block: got %h expected FFFF", oComInd);
      else pass_cnt++;
      do_write(2'd3, 16'h00A4);
      do_write(2'd2, 16'h0002);
      iBl = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (oComInd !== 16'h0000)
         $display("FAIL lamp: got %h expected 0000", oComInd);
      else pass_cnt++;
      do_read(2'd2, d);
      total++;
      if (d !== 16'h0002) $display("FAIL ctrl_rd: got %h expected 0002", d);
      else pass_cnt++;
   endtask

   task automatic test_test_out();
      logic [15:0] d;
      logic        ref_v;
      do_write(2'd3, 16'h00A4);
      do_write(2'd2, 16'hFFFD);
      @(negedge clk);
      ref_v = test;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         total++;
         if (test !== (ref_v ^ i[0]))
            $display("FAIL test_tog_%0d: got %b expected %b",
                     i, test, ref_v ^ i[0]);
         else pass_cnt++;
      end
      do_read(2'd2, d);
      total++;
      if (d !== 16'h0001) $display("FAIL ctrl_hi: got %h expected 0001", d);
      else pass_cnt++;
      total++;
      if (oComInd !== 16'h55AA)
         $display("FAIL lamp_off: got %h expected 55AA", oComInd);
      else pass_cnt++;
      do_write(2'd3, 16'h00A4);
      @(negedge clk);
      iA       = 2'd1;
      r_drv    = 16'h0000;
      r_drv_en = 1'b1;
      iWr      = 1'b0;
      @(negedge clk);
      iRes = 1'b0;
      #1;
      total++;
      if (test !== 1'b0 || oComInd !== 16'hFFFF)
         $display("FAIL rst_async: test=%b ind=%h expected 0 FFFF", test, oComInd);
      else pass_cnt++;
      repeat (4) @(negedge clk);
      iWr      = 1'b1;
      r_drv_en = 1'b0;
      do_read(2'd2, d);
      total++;
      if (d !== 16'h0000) $display("FAIL rst_ctrl: got %h expected 0000", d);
      else pass_cnt++;
      do_read(2'd1, d);
      total++;
      if (d !== 16'h00FF) $display("FAIL rst_mask3: got %h expected 00FF", d);
      else pass_cnt++;
   endtask

   initial begin
      iRes     = 1'b0;
      iRd      = 1'b1;
      iWr      = 1'b1;
      iBl      = 1'b1;
      iDevice  = 1'b0;
      iA       = 2'd0;
      iCS      = 4'b0000;
      iCom     = 16'h0000;
      r_drv    = 16'h0000;
      r_drv_en = 1'b0;
      #2;
      test_cs();
      test_reset();
      test_com();
      test_mask_lock();
      test_rd_wr_conflict();
      test_block();
      test_test_out();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
